// File: rtl/if_fetch.sv
// Instruction-fetch stage: owns the PC, pipelines imem requests and buffers responses for ID.
// Optional IF_BYPASS_EN: a response that finds the FIFO empty is forwarded to ID in the same cycle.
module if_fetch #(
  parameter int unsigned       ADDR_W     = 32,
  parameter int unsigned       INST_W     = 32,
  parameter logic [ADDR_W-1:0] RESET_ADDR = 32'h0000_0000,
  parameter int unsigned       DEPTH      = 2,
  parameter logic [INST_W-1:0] NOP_INST   = 32'h0000_0013
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req_o,
  output logic [ADDR_W-1:0] imem_addr_o,
  input  logic              imem_gnt_i,
  input  logic              imem_rvalid_i,
  input  logic [INST_W-1:0] imem_rdata_i,
  input  logic              jump_en_i,
  input  logic [ADDR_W-1:0] jump_addr_i,
  input  logic              id_ready_i,
  output logic              inst_valid_o,
  output logic [INST_W-1:0] inst_o,
  output logic [ADDR_W-1:0] inst_addr_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] resp_addr_q, resp_addr_d;
  logic [CNT_W-1:0]  out_q, out_d;
  logic [CNT_W-1:0]  discard_q, discard_d;
  logic [ADDR_W-1:0] last_addr_q;

  logic [ADDR_W-1:0] fifo_addr_q [DEPTH];
  logic [INST_W-1:0] fifo_data_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]  count_q;

  logic              fifo_empty;
  logic [ADDR_W-1:0] head_addr;
  logic [INST_W-1:0] head_data;
  logic [CNT_W:0]    inflight;
  logic              credit_ok;
  logic [ADDR_W-1:0] jump_tgt;

  logic              req;
  logic              push;
  logic              pop;
  logic              flush;
  logic              bypass;
  logic              valid_c;
  logic [INST_W-1:0] inst_c;
  logic [ADDR_W-1:0] inst_addr_c;

  assign fifo_empty = (count_q == '0);
  assign head_addr  = fifo_addr_q[rd_ptr_q];
  assign head_data  = fifo_data_q[rd_ptr_q];
  // Words in flight plus words buffered may never exceed the FIFO size.
  assign inflight   = {1'b0, out_q} + {1'b0, count_q};
  assign credit_ok  = (inflight < (CNT_W + 1)'(DEPTH));
  assign jump_tgt   = {jump_addr_i[ADDR_W-1:2], 2'b00};

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    resp_addr_d = resp_addr_q;
    out_d       = out_q;
    discard_d   = discard_q;
    req         = 1'b0;
    push        = 1'b0;
    pop         = 1'b0;
    flush       = 1'b0;
    bypass      = 1'b0;
    valid_c     = ~fifo_empty & ~jump_en_i;
    inst_c      = fifo_empty ? NOP_INST : head_data;
    inst_addr_c = fifo_empty ? last_addr_q : head_addr;

`ifdef IF_BYPASS_EN
    if (fifo_empty && (discard_q == '0) && !jump_en_i && imem_rvalid_i) begin
      bypass      = 1'b1;
      valid_c     = 1'b1;
      inst_c      = imem_rdata_i;
      inst_addr_c = resp_addr_q;
    end
`endif

    case (state_q)
      IDLE:    state_d = RUN;
      RUN:     req = credit_ok & ~jump_en_i;
      default: req = 1'b0;
    endcase

    if (req && imem_gnt_i) begin
      pc_d = pc_q + ADDR_W'(4);
    end

    case ({req & imem_gnt_i, imem_rvalid_i})
      2'b10:   out_d = out_q + CNT_W'(1);
      2'b01:   out_d = out_q - CNT_W'(1);
      default: out_d = out_q;
    endcase

    if (imem_rvalid_i) begin
      if (discard_q != '0) begin
        discard_d = discard_q - CNT_W'(1);
        if (discard_d == '0) begin
          state_d = RUN;
        end
      end else begin
        resp_addr_d = resp_addr_q + ADDR_W'(4);
        push        = ~(bypass & id_ready_i);
      end
    end

    pop = valid_c & id_ready_i & ~fifo_empty;

    // A redirect overrides everything: buffered words die, in-flight ones are dropped on arrival.
    if (jump_en_i) begin
      flush       = 1'b1;
      push        = 1'b0;
      pop         = 1'b0;
      pc_d        = jump_tgt;
      resp_addr_d = jump_tgt;
      discard_d   = imem_rvalid_i ? (out_q - CNT_W'(1)) : out_q;
      state_d     = (discard_d != '0) ? DRAIN : RUN;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      pc_q        <= RESET_ADDR;
      resp_addr_q <= RESET_ADDR;
      out_q       <= '0;
      discard_q   <= '0;
      last_addr_q <= RESET_ADDR;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      resp_addr_q <= resp_addr_d;
      out_q       <= out_d;
      discard_q   <= discard_d;
      if (!fifo_empty || bypass) begin
        last_addr_q <= inst_addr_c;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr_q[wr_ptr_q] <= resp_addr_q;
      fifo_data_q[wr_ptr_q] <= imem_rdata_i;
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(imem_rvalid_i && (count_q == CNT_W'(DEPTH))));

  assign imem_req_o   = req;
  assign imem_addr_o  = pc_q;
  assign inst_valid_o = valid_c;
  assign inst_o       = inst_c;
  assign inst_addr_o  = inst_addr_c;

endmodule

// File: tb/tb_if_fetch.sv
// Bench for if_fetch: cycle vector table, directed jump/reset sequences, randomized run vs. a stream scoreboard.
module tb_if_fetch;

  localparam int          DEPTH = 2;
  localparam logic [31:0] NOP   = 32'h0000_0013;
`ifdef IF_BYPASS_EN
  localparam bit BP = 1'b1;
`else
  localparam bit BP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic        jump_en_i;
  logic [31:0] jump_addr_i;
  logic        id_ready_i;
  logic        inst_valid_o;
  logic [31:0] inst_o;
  logic [31:0] inst_addr_o;

  if_fetch #(
    .ADDR_W(32), .INST_W(32), .RESET_ADDR(32'h0000_0000), .DEPTH(DEPTH), .NOP_INST(NOP)
  ) dut (
    .clk(clk), .rst(rst),
    .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o), .imem_gnt_i(imem_gnt_i),
    .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
    .jump_en_i(jump_en_i), .jump_addr_i(jump_addr_i), .id_ready_i(id_ready_i),
    .inst_valid_o(inst_valid_o), .inst_o(inst_o), .inst_addr_o(inst_addr_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0b expected %0b", name, act, exp);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Table: per-cycle inputs and expected outputs (vbp = expected valid with bypass built in).
  typedef struct {
    logic        gnt;
    logic        rv;
    logic [31:0] ra;
    logic        rdy;
    logic        jmp;
    logic [31:0] ja;
    logic        req;
    logic [31:0] addr;
    logic        v;
    logic        vbp;
    logic [31:0] ia;
  } vec_t;

  vec_t tbl [19];

  function automatic vec_t mk(input logic gnt, input logic rv, input logic [31:0] ra,
                              input logic rdy, input logic jmp, input logic [31:0] ja,
                              input logic req, input logic [31:0] addr,
                              input logic v, input logic vbp, input logic [31:0] ia);
    vec_t r;
    r.gnt = gnt; r.rv = rv; r.ra = ra; r.rdy = rdy; r.jmp = jmp; r.ja = ja;
    r.req = req; r.addr = addr; r.v = v; r.vbp = vbp; r.ia = ia;
    return r;
  endfunction

  // Memory model: in-order responses, each at least one cycle after its grant.
  typedef struct {
    logic [31:0] a;
    int          due;
  } pend_t;

  pend_t       pend [$];
  int          cyc = 0;
  int          last_due = 0;
  int          lat_max = 1;
  int          gnt_pct = 100;
  int          rdy_pct = 100;
  int          jmp_pm = 0;
  logic [31:0] exp_fetch = 32'h0;
  logic [31:0] exp_deliver = 32'h0;
  int          n_deliv = 0;
  int          n_grant = 0;

  task automatic do_reset();
    rst           = 1'b1;
    imem_gnt_i    = 1'b0;
    imem_rvalid_i = 1'b0;
    imem_rdata_i  = 32'h0;
    jump_en_i     = 1'b0;
    jump_addr_i   = 32'h0;
    id_ready_i    = 1'b0;
    pend.delete();
    last_due      = 0;
    exp_fetch     = 32'h0;
    exp_deliver   = 32'h0;
    #1;
    chk1("rst_req", imem_req_o, 1'b0);
    chk32("rst_addr", imem_addr_o, 32'h0);
    chk1("rst_valid", inst_valid_o, 1'b0);
    chk32("rst_inst", inst_o, NOP);
    chk32("rst_inst_addr", inst_addr_o, 32'h0);
    $display("reset: req=%0b addr=%h valid=%0b inst=%h", imem_req_o, imem_addr_o, inst_valid_o, inst_o);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic drive(input logic gnt, input logic rv, input logic [31:0] ra,
                       input logic rdy, input logic jmp, input logic [31:0] ja);
    imem_gnt_i    = gnt;
    imem_rvalid_i = rv;
    imem_rdata_i  = memf(ra);
    id_ready_i    = rdy;
    jump_en_i     = jmp;
    jump_addr_i   = ja;
  endtask

  task automatic auto_cycle();
    int lat;
    int due;
    imem_gnt_i  = (int'($urandom_range(99)) < gnt_pct);
    id_ready_i  = (int'($urandom_range(99)) < rdy_pct);
    jump_en_i   = (int'($urandom_range(999)) < jmp_pm);
    jump_addr_i = $urandom;
    if (pend.size() > 0 && pend[0].due <= cyc) begin
      imem_rvalid_i = 1'b1;
      imem_rdata_i  = memf(pend[0].a);
    end else begin
      imem_rvalid_i = 1'b0;
      imem_rdata_i  = $urandom;
    end
    @(negedge clk);
    if (imem_req_o) chk1("credit", (pend.size() < DEPTH), 1'b1);
    if (imem_req_o && imem_gnt_i) begin
      chk32("fetch_addr", imem_addr_o, exp_fetch);
      lat = int'($urandom_range(lat_max, 1));
      due = cyc + lat;
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      pend.push_back('{a: imem_addr_o, due: due});
      exp_fetch = exp_fetch + 32'd4;
      n_grant++;
    end
    if (imem_rvalid_i) void'(pend.pop_front());
    if (jump_en_i) begin
      chk1("no_valid_on_jump", inst_valid_o, 1'b0);
      exp_fetch   = {jump_addr_i[31:2], 2'b00};
      exp_deliver = exp_fetch;
      $display("cyc %0d: jump to %h", cyc, exp_fetch);
    end else if (inst_valid_o && id_ready_i) begin
      chk32("deliver_addr", inst_addr_o, exp_deliver);
      chk32("deliver_data", inst_o, memf(exp_deliver));
      $display("cyc %0d: deliver addr=%h inst=%h", cyc, inst_addr_o, inst_o);
      exp_deliver = exp_deliver + 32'd4;
      n_deliv++;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    logic ev;
    bit   found;

    //            gnt rv  ra        rdy jmp ja            req addr       v  vbp ia
    tbl[0]  = mk(1, 0, 32'h000, 0, 0, 32'h0,   0, 32'h000, 0, 0, 32'h000);
    tbl[1]  = mk(1, 0, 32'h000, 0, 0, 32'h0,   1, 32'h000, 0, 0, 32'h000);
    tbl[2]  = mk(1, 1, 32'h000, 0, 0, 32'h0,   1, 32'h004, 0, 1, 32'h000);
    tbl[3]  = mk(1, 1, 32'h004, 0, 0, 32'h0,   0, 32'h008, 1, 1, 32'h000);
    tbl[4]  = mk(1, 0, 32'h000, 0, 0, 32'h0,   0, 32'h008, 1, 1, 32'h000);
    tbl[5]  = mk(0, 0, 32'h000, 1, 0, 32'h0,   0, 32'h008, 1, 1, 32'h000);
    tbl[6]  = mk(0, 0, 32'h000, 0, 0, 32'h0,   1, 32'h008, 1, 1, 32'h004);
    tbl[7]  = mk(0, 0, 32'h000, 0, 0, 32'h0,   1, 32'h008, 1, 1, 32'h004);
    tbl[8]  = mk(1, 0, 32'h000, 0, 0, 32'h0,   1, 32'h008, 1, 1, 32'h004);
    tbl[9]  = mk(1, 1, 32'h008, 1, 0, 32'h0,   0, 32'h00C, 1, 1, 32'h004);
    tbl[10] = mk(1, 0, 32'h000, 0, 0, 32'h0,   1, 32'h00C, 1, 1, 32'h008);
    tbl[11] = mk(0, 0, 32'h000, 0, 1, 32'h103, 0, 32'h010, 0, 0, 32'h000);
    tbl[12] = mk(1, 0, 32'h000, 1, 0, 32'h0,   0, 32'h100, 0, 0, 32'h000);
    tbl[13] = mk(1, 1, 32'h00C, 1, 0, 32'h0,   0, 32'h100, 0, 0, 32'h000);
    tbl[14] = mk(1, 0, 32'h000, 1, 0, 32'h0,   1, 32'h100, 0, 0, 32'h000);
    tbl[15] = mk(1, 1, 32'h100, 0, 0, 32'h0,   1, 32'h104, 0, 1, 32'h100);
    tbl[16] = mk(0, 1, 32'h104, 1, 0, 32'h0,   0, 32'h108, 1, 1, 32'h100);
    tbl[17] = mk(0, 0, 32'h000, 1, 0, 32'h0,   1, 32'h108, 1, 1, 32'h104);
    tbl[18] = mk(0, 0, 32'h000, 1, 0, 32'h0,   1, 32'h108, 0, 0, 32'h000);

    #2;
    do_reset();
    for (int i = 0; i < 19; i++) begin
      drive(tbl[i].gnt, tbl[i].rv, tbl[i].ra, tbl[i].rdy, tbl[i].jmp, tbl[i].ja);
      @(negedge clk);
      ev = BP ? tbl[i].vbp : tbl[i].v;
      chk1($sformatf("vec%0d_req", i), imem_req_o, tbl[i].req);
      if (tbl[i].req) chk32($sformatf("vec%0d_addr", i), imem_addr_o, tbl[i].addr);
      chk1($sformatf("vec%0d_valid", i), inst_valid_o, ev);
      if (ev) begin
        chk32($sformatf("vec%0d_inst_addr", i), inst_addr_o, tbl[i].ia);
        chk32($sformatf("vec%0d_inst", i), inst_o, memf(tbl[i].ia));
      end
      $display("vec %0d: req=%0b addr=%h valid=%0b inst_addr=%h inst=%h",
               i, imem_req_o, imem_addr_o, inst_valid_o, inst_addr_o, inst_o);
      @(posedge clk);
      #1;
    end

    // Jump on the same cycle as an rvalid and a would-be pop.
    do_reset();
    drive(1, 0, 32'h0, 0, 0, 32'h0); @(posedge clk); #1;
    drive(1, 0, 32'h0, 0, 0, 32'h0); @(posedge clk); #1;
    drive(1, 1, 32'h0, 0, 0, 32'h0); @(posedge clk); #1;
    drive(1, 1, 32'h4, 1, 1, 32'h203);
    @(negedge clk);
    chk1("jmp_rv_valid", inst_valid_o, 1'b0);
    chk1("jmp_rv_req", imem_req_o, 1'b0);
    $display("jump+rvalid+pop: valid=%0b req=%0b", inst_valid_o, imem_req_o);
    @(posedge clk); #1;
    drive(0, 0, 32'h0, 1, 0, 32'h0);
    @(negedge clk);
    chk1("post_jmp_valid", inst_valid_o, 1'b0);
    chk1("post_jmp_req", imem_req_o, 1'b1);
    chk32("post_jmp_addr", imem_addr_o, 32'h200);
    $display("after jump: valid=%0b req=%0b addr=%h", inst_valid_o, imem_req_o, imem_addr_o);
    @(posedge clk); #1;

    // Reset asserted mid-stream once the PC reaches 0x40.
    do_reset();
    gnt_pct = 100; rdy_pct = 100; jmp_pm = 0; lat_max = 1;
    found = 1'b0;
    for (int k = 0; k < 100 && !found; k++) begin
      auto_cycle();
      if (imem_req_o && imem_addr_o == 32'h40) found = 1'b1;
    end
    chk1("reach_pc40", found, 1'b1);
    do_reset();
    n_grant = 0;
    for (int k = 0; k < 8; k++) auto_cycle();
    chk1("restart_grants", (n_grant > 0), 1'b1);

    // Randomized traffic with redirects, then a redirect-free tail.
    do_reset();
    n_deliv = 0;
    gnt_pct = 70; rdy_pct = 60; jmp_pm = 20; lat_max = 3;
    for (int k = 0; k < 500; k++) auto_cycle();
    gnt_pct = 100; rdy_pct = 100; jmp_pm = 0;
    for (int k = 0; k < 60; k++) auto_cycle();
    chk1("deliveries", (n_deliv >= 50), 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish within bound");
    $fatal(1, "timeout");
  end

endmodule
